gpr_wb_arb: RTL and testbench
=============================

# gpr_wb_arb

Write-port arbiter and scoreboard for the general-purpose register file. Merges the in-order pipeline writeback with results returned by long-latency units (mul/div, load return) onto the file's single write port. Buffers long-latency results in a small FIFO and tracks outstanding long-latency destinations so decode can stall on RAW hazards. Sits between the writeback stage, the long-latency units and the register file write port; register 0 is never written.

## Interface
- `DEPTH`, 2: long-latency FIFO entries (power of two, ≥2).
- `STARVE_MAX`, 4: consecutive cycles a waiting FIFO head may lose before the pipeline is held.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `wb_regf` in 5: pipeline writeback destination; 0 = no write.
- `wb_data` in 32: pipeline writeback data.
- `wb_hold` out 1: pipeline must not retire its writeback this cycle and must re-present it next cycle.
- `ll_valid` in 1: long-latency result valid.
- `ll_ready` out 1: FIFO can accept.
- `ll_regf` in 5, `ll_data` in 32: long-latency destination/data.
- `iss_valid` in 1, `iss_regf` in 5: long-latency op issued with this destination.
- `rs_regf`, `rt_regf` in 5 each: decode source registers.
- `rs_busy`, `rt_busy` out 1 each: source has an outstanding long-latency write.
- `gpr_w` out: regf_w master (`regf` 5, `data` 32) to the register file.

## Operation
- Long-latency handshake: a transfer occurs when `ll_valid && ll_ready`. `ll_ready = !full`. `ll_regf == 0` is accepted and dropped.
- Each cycle, exactly one source drives `gpr_w`, in this order:
  - If `wb_hold` is asserted, the FIFO head is selected.
  - Otherwise, if `wb_regf != 0`, the pipeline is selected.
  - Otherwise, the FIFO head is selected if non-empty.
  - Otherwise, `gpr_w.regf = 0` (idle).
- The pipeline never waits except under `wb_hold`.
- Starvation counter `cnt`:
  - Increments each cycle the FIFO is non-empty and the pipeline wins.
  - Clears when the head commits or the FIFO is empty.
  - `wb_hold = (cnt == STARVE_MAX)`, decoded from registered state only.
- Scoreboard `pend[31:1]`:
  - Set on `iss_valid && iss_regf != 0`.
  - Cleared when a FIFO head with that regf commits.
  - Simultaneous set and clear of the same register: set wins.
  - Two outstanding ops to the same register are illegal; undefined.
- `rs_busy = pend[rs_regf]`, `rt_busy = pend[rt_regf]`; register 0 always reads not busy.

## Timing
- Reset (`rst_n` low at a clock edge) empties the FIFO and clears `pend` and `cnt`.
- Outputs while reset is held and in the first cycle after release: `gpr_w.regf = 0`, `ll_ready = 0` while held, `wb_hold = 0`, busy outputs 0.
- Reset mid-operation discards buffered results without writing them.
- `gpr_w` is combinational from the current-cycle inputs and FIFO state; the register file captures it at the next edge.
- Long-latency latency: accepted at edge t, committed at edge t+1 at the earliest (FIFO path).
- Full FIFO with a commit in the same cycle: `ll_ready` stays 0 that cycle (no read-before-write pass-through).
- Scoreboard update is visible on `*_busy` the cycle after the issue/commit edge.

## Configuration
- `GPR_WB_BYPASS_EN` defined:
  - If the FIFO is empty, `wb_regf == 0` and `wb_hold == 0`, an incoming `ll_valid` result drives `gpr_w` in the same cycle and is not enqueued.
  - Its `pend` bit clears at that edge.
  - `ll_ready` is unchanged by bypass.
- Undefined: every long-latency result passes through the FIFO, giving a minimum latency of one cycle.

## Structure
- The shared package holds `GPR_ADDR_W = 5`, `GPR_DATA_W = 32`, and a packed `gpr_wr_t {regf, data}` used for FIFO entries.
- One sub-module, `wb_fifo`: parameterised synchronous FIFO with `DEPTH` entries, pointer wrap-around and full/empty flags.
- Arbitration, counter and scoreboard live in the top level.

## Test plan
- **Reset:** hold `rst_n = 0` with `wb_regf = 5`, `ll_valid = 1` → `gpr_w.regf = 0`, `ll_ready = 0`, no register written.
- **Idle long-latency:** `iss_regf = 8`, later `ll_regf = 8`, `ll_data = 0xDEADBEEF` with the pipeline idle → `rs_busy` is 1 for `rs_regf = 8` until commit; the write appears one cycle after acceptance (same cycle with `GPR_WB_BYPASS_EN`); `rs_busy` drops the next cycle.
- **Contention:** pipeline writes every cycle while one long-latency result is buffered → `wb_hold` rises after 4 lost cycles; the head commits in the hold cycle; `cnt` clears; the held pipeline write commits next cycle.
- **FIFO full:** two results accepted while the pipeline writes continuously → `ll_ready = 0`; a third `ll_valid` is held and accepted only after a commit frees an entry.
- **Simultaneous scoreboard:** FIFO head to r3 commits in the same cycle as `iss_regf = 3` → `pend[3]` stays 1.
- **Register 0:** `ll_regf = 0` accepted → no write issued; `iss_regf = 0` → `rs_busy = 0` for `rs_regf = 0`.

Source files
------------

// File: rtl/gpr_wb_arb_pkg.sv
// Shared types and constants for the GPR write-port arbiter.
package gpr_wb_arb_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_REGS   = 1 << GPR_ADDR_W;

  // One register-file write: destination and data. Also the FIFO entry format.
  typedef struct packed {
    logic [GPR_ADDR_W-1:0] regf;
    logic [GPR_DATA_W-1:0] data;
  } gpr_wr_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_BYP
  } wr_src_e;

endpackage

// File: rtl/gpr_wb_arb_wb_fifo.sv
// Synchronous FIFO for buffered long-latency results.
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit
// so that full and empty are distinguishable.
module wb_fifo import gpr_wb_arb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  gpr_wr_t din,
  input  logic    pop,
  output gpr_wr_t dout,
  output logic    full,
  output logic    empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  gpr_wr_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage.
  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gpr_wb_arb.sv
// GPR write-port arbiter and RAW scoreboard.
// Merges pipeline writeback with buffered long-latency results onto one
// register-file write port, holds the pipeline when the FIFO head starves,
// and tracks outstanding long-latency destinations for decode stalls.
// Optional: define GPR_WB_BYPASS_EN to let a long-latency result write
// straight through when the port and FIFO are both idle.
module gpr_wb_arb import gpr_wb_arb_pkg::*; #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GPR_ADDR_W-1:0] wb_regf,
  input  logic [GPR_DATA_W-1:0] wb_data,
  output logic                  wb_hold,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [GPR_ADDR_W-1:0] ll_regf,
  input  logic [GPR_DATA_W-1:0] ll_data,
  input  logic                  iss_valid,
  input  logic [GPR_ADDR_W-1:0] iss_regf,
  input  logic [GPR_ADDR_W-1:0] rs_regf,
  input  logic [GPR_ADDR_W-1:0] rt_regf,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output gpr_wr_t               gpr_w
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  wr_src_e               src;
  gpr_wr_t               fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [CNT_W-1:0]      cnt;
  logic [GPR_REGS-1:0]   pend;
  logic [GPR_REGS-1:0]   pend_d;
  logic [GPR_ADDR_W-1:0] commit_regf;

  // Starvation hold comes only from registered state.
  assign wb_hold  = (cnt == CNT_W'(STARVE_MAX));
  assign ll_ready = rst_n && !fifo_full;

  // Write-port source selection in priority order.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src = SRC_IDLE;
    if (!rst_n)                src = SRC_IDLE;
    else if (wb_hold)          src = fifo_empty ? SRC_IDLE : SRC_FIFO;
    else if (wb_regf != '0)    src = SRC_PIPE;
    else if (!fifo_empty)      src = SRC_FIFO;
`ifdef GPR_WB_BYPASS_EN
    else if (ll_valid && ll_regf != '0) src = SRC_BYP;
`endif
  end

  // Drive the write port from the selected source.
  always_comb begin
    gpr_w = '0;
    unique case (src)
      SRC_PIPE: begin
        gpr_w.regf = wb_regf;
        gpr_w.data = wb_data;
      end
      SRC_FIFO: gpr_w = fifo_head;
      SRC_BYP: begin
        gpr_w.regf = ll_regf;
        gpr_w.data = ll_data;
      end
      default: gpr_w = '0;
    endcase
  end

  // Results to r0 are accepted and dropped; bypassed results skip the FIFO.
  assign fifo_push   = ll_valid && ll_ready && (ll_regf != '0) && (src != SRC_BYP);
  assign fifo_pop    = (src == SRC_FIFO);
  assign commit_regf = (src == SRC_FIFO || src == SRC_BYP) ? gpr_w.regf : '0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({ll_regf, ll_data}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Count consecutive cycles the waiting FIFO head loses to the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n)                               cnt <= '0;
    else if (fifo_empty || src == SRC_FIFO)   cnt <= '0;
    else if (src == SRC_PIPE)                 cnt <= cnt + CNT_W'(1);
  end

  // Scoreboard next state: clear on commit, then set on issue so set wins.
  always_comb begin
    pend_d = pend;
    if (commit_regf != '0)             pend_d[commit_regf] = 1'b0;
    if (iss_valid && iss_regf != '0)   pend_d[iss_regf]    = 1'b1;
  end

  // Scoreboard register; bit 0 is never set so r0 always reads not busy.
  always_ff @(posedge clk) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_d;
  end

  assign rs_busy = pend[rs_regf];
  assign rt_busy = pend[rt_regf];

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Self-checking bench for gpr_wb_arb: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_gpr_wb_arb;
  import gpr_wb_arb_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wb_regf;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_regf;
  logic [31:0] ll_data;
  logic        iss_valid;
  logic [4:0]  iss_regf;
  logic [4:0]  rs_regf;
  logic [4:0]  rt_regf;
  logic        rs_busy;
  logic        rt_busy;
  gpr_wr_t     gpr_w;

  gpr_wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regf(wb_regf), .wb_data(wb_data), .wb_hold(wb_hold),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_regf(ll_regf), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_regf(iss_regf),
    .rs_regf(rs_regf), .rt_regf(rt_regf), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .gpr_w(gpr_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending results in order, lost-cycle count, scoreboard.
  gpr_wr_t   m_q[$];
  int        m_lost = 0;
  bit [31:0] m_pend = '0;

  // Last observed DUT outputs, for directed checks.
  logic        obs_hold, obs_ready, obs_rs, obs_rt;
  logic [4:0]  obs_regf;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs already applied; compare against model, then advance it.
  task automatic cycle();
    gpr_wr_t exp_w;
    bit      exp_hold, exp_ready, from_q, was_empty;
    bit      exp_rs, exp_rt;
    #1;
    exp_hold  = (m_lost == STARVE_MAX);
    exp_ready = rst_n && (m_q.size() < DEPTH);
    from_q    = 1'b0;
    exp_w     = '0;
    if (!rst_n) begin
      exp_w = '0;
    end else if (exp_hold && m_q.size() != 0) begin
      exp_w = m_q[0]; from_q = 1'b1;
    end else if (wb_regf != 5'd0) begin
      exp_w.regf = wb_regf; exp_w.data = wb_data;
    end else if (m_q.size() != 0) begin
      exp_w = m_q[0]; from_q = 1'b1;
    end
    exp_rs = (rs_regf != 5'd0) && m_pend[rs_regf];
    exp_rt = (rt_regf != 5'd0) && m_pend[rt_regf];

    check("gpr_regf", 32'(gpr_w.regf), 32'(exp_w.regf));
    if (exp_w.regf != 5'd0) check("gpr_data", gpr_w.data, exp_w.data);
    check("wb_hold",  32'(wb_hold),  32'(exp_hold));
    check("ll_ready", 32'(ll_ready), 32'(exp_ready));
    check("rs_busy",  32'(rs_busy),  32'(exp_rs));
    check("rt_busy",  32'(rt_busy),  32'(exp_rt));

    obs_hold = wb_hold; obs_ready = ll_ready; obs_rs = rs_busy; obs_rt = rt_busy;
    obs_regf = gpr_w.regf; obs_data = gpr_w.data;

    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_lost = 0;
      m_pend = '0;
    end else begin
      was_empty = (m_q.size() == 0);
      if (from_q) begin
        m_pend[exp_w.regf] = 1'b0;
        void'(m_q.pop_front());
      end
      if (was_empty || from_q) m_lost = 0;
      else                     m_lost++;
      if (ll_valid && exp_ready && ll_regf != 5'd0) begin
        gpr_wr_t e;
        e.regf = ll_regf; e.data = ll_data;
        m_q.push_back(e);
      end
      if (iss_valid && iss_regf != 5'd0) m_pend[iss_regf] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_regf = '0; wb_data = '0; ll_valid = 1'b0; ll_regf = '0; ll_data = '0;
    iss_valid = 1'b0; iss_regf = '0; rs_regf = '0; rt_regf = '0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int  lost;
    bit  seen, saw_commit, accepted;
    logic [4:0] r;

    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);

    // Reset held with live inputs: nothing written, not ready.
    wb_regf = 5'd5; wb_data = 32'h55; ll_valid = 1'b1; ll_regf = 5'd7; ll_data = 32'h77;
    rs_regf = 5'd7;
    cycle();
    check("rst_regf",  32'(obs_regf),  32'd0);
    check("rst_ready", 32'(obs_ready), 32'd0);
    cycle();
    check("rst_hold",  32'(obs_hold),  32'd0);
    rst_n = 1'b1;
    idle_inputs();
    cycle();
    check("post_rst_regf", 32'(obs_regf), 32'd0);
    check("post_rst_busy", 32'(obs_rs),   32'd0);

    // Idle long-latency write to r8.
    iss_valid = 1'b1; iss_regf = 5'd8; rs_regf = 5'd8;
    cycle();
    iss_valid = 1'b0;
    cycle();
    check("ll_busy_set", 32'(obs_rs), 32'd1);
    ll_valid = 1'b1; ll_regf = 5'd8; ll_data = 32'hDEADBEEF;
    cycle();
    check("ll_accept_ready", 32'(obs_ready), 32'd1);
    check("ll_no_write_yet", 32'(obs_regf),  32'd0);
    ll_valid = 1'b0;
    cycle();
    check("ll_commit_regf", 32'(obs_regf), 32'd8);
    check("ll_commit_data", obs_data,      32'hDEADBEEF);
    check("ll_busy_commit", 32'(obs_rs),   32'd1);
    cycle();
    check("ll_busy_clear",  32'(obs_rs),   32'd0);

    // Contention: pipeline writes every cycle while one result waits.
    wb_regf = 5'd1; wb_data = 32'h1111; ll_valid = 1'b1; ll_regf = 5'd9; ll_data = 32'h9999;
    cycle();
    ll_valid = 1'b0;
    lost = 0; seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle();
      if (obs_hold) seen = 1'b1;
      else          lost++;
    end
    check("starve_seen",   32'(seen),     32'd1);
    check("starve_lost",   32'(lost),     32'd4);
    check("starve_head",   32'(obs_regf), 32'd9);
    cycle();
    check("held_wb_regf",  32'(obs_regf), 32'd1);
    check("hold_released", 32'(obs_hold), 32'd0);
    drain(3);

    // FIFO full under continuous pipeline writes.
    wb_regf = 5'd20; wb_data = 32'h2020;
    ll_valid = 1'b1; ll_regf = 5'd10; ll_data = 32'hA;
    cycle();
    ll_regf = 5'd11; ll_data = 32'hB;
    cycle();
    ll_regf = 5'd12; ll_data = 32'hC;
    cycle();
    check("full_ready", 32'(obs_ready), 32'd0);
    accepted = 1'b0; saw_commit = 1'b0;
    for (int i = 0; i < 12 && !accepted; i++) begin
      cycle();
      if (obs_regf == 5'd10) saw_commit = 1'b1;
      if (obs_ready) accepted = 1'b1;
    end
    check("full_accept",      32'(accepted),   32'd1);
    check("full_commit_first", 32'(saw_commit), 32'd1);
    drain(6);

    // Commit of r3 coincides with a new issue to r3: busy stays set.
    iss_valid = 1'b1; iss_regf = 5'd3;
    cycle();
    iss_valid = 1'b0; ll_valid = 1'b1; ll_regf = 5'd3; ll_data = 32'h3333;
    cycle();
    ll_valid = 1'b0; iss_valid = 1'b1; iss_regf = 5'd3;
    cycle();
    check("sim_commit_r3", 32'(obs_regf), 32'd3);
    iss_valid = 1'b0; rs_regf = 5'd3;
    cycle();
    check("sim_busy_r3", 32'(obs_rs), 32'd1);
    ll_valid = 1'b1; ll_regf = 5'd3; ll_data = 32'h3334;
    cycle();
    drain(3);

    // Register 0: result accepted and dropped; issue to r0 never busy.
    ll_valid = 1'b1; ll_regf = 5'd0; ll_data = 32'hFFFF;
    iss_valid = 1'b1; iss_regf = 5'd0; rs_regf = 5'd0;
    cycle();
    check("r0_ready", 32'(obs_ready), 32'd1);
    ll_valid = 1'b0; iss_valid = 1'b0;
    cycle();
    check("r0_no_write", 32'(obs_regf), 32'd0);
    check("r0_not_busy", 32'(obs_rs),   32'd0);

    // Reset mid-operation discards buffered results and pending bits.
    wb_regf = 5'd21; wb_data = 32'h21; iss_valid = 1'b1; iss_regf = 5'd13;
    ll_valid = 1'b1; ll_regf = 5'd13; ll_data = 32'h1313;
    cycle();
    rst_n = 1'b0; idle_inputs();
    cycle();
    rst_n = 1'b1; rs_regf = 5'd13;
    cycle();
    check("mid_rst_no_write", 32'(obs_regf), 32'd0);
    check("mid_rst_not_busy", 32'(obs_rs),   32'd0);

    // Randomized traffic.
    idle_inputs();
    obs_hold = 1'b0; obs_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if (!obs_hold) begin
        wb_regf = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data = $urandom;
      end
      if (!(ll_valid && !obs_ready)) begin
        ll_valid = ($urandom_range(0, 2) == 0);
        ll_regf  = 5'($urandom_range(0, 31));
        ll_data  = $urandom;
      end
      r = 5'($urandom_range(0, 31));
      iss_valid = ($urandom_range(0, 3) == 0) && !m_pend[r];
      iss_regf  = r;
      rs_regf   = 5'($urandom_range(0, 31));
      rt_regf   = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
